// File: rtl/sig_sync_pkg.sv
// ----------------------------------------------------------------------------
// sig_sync_pkg
//   Shared definitions for the multi-channel level synchronizer bank.
//   Contents:
//     chan_out_t    - per-channel result bundle (level, edge pulses, sticky flag)
//     cnt_width()   - bit width of the stability counter for a given
//                     FILTER_CYCLES (clog2(FILTER_CYCLES+1), never below 1)
//     params_legal()- parameter sanity check used at elaboration time
//   Build option: SIG_SYNC_BANK_FILTER_EN (see sig_sync_chan) enables the
//   stability filter; this package is the same in both builds.
// ----------------------------------------------------------------------------
package sig_sync_pkg;

    localparam int MIN_WIDTH         = 1;
    localparam int MIN_STAGES        = 2;
    localparam int MIN_FILTER_CYCLES = 1;

    // Everything one channel hands back to the bank.
    typedef struct packed {
        logic sync;
        logic rise;
        logic fall;
        logic pend;
    } chan_out_t;

    // The counter has to reach FILTER_CYCLES-1; a 1-bit floor keeps the
    // FILTER_CYCLES=1 case from collapsing into a zero-width vector.
    function automatic int cnt_width(input int filter_cycles);
        int w;
        w = $clog2(filter_cycles + 1);
        if (w < 1) begin
            w = 1;
        end
        return w;
    endfunction

    function automatic bit params_legal(input int width,
                                        input int stages,
                                        input int filter_cycles);
        return (width >= MIN_WIDTH) &&
               (stages >= MIN_STAGES) &&
               (filter_cycles >= MIN_FILTER_CYCLES);
    endfunction

endpackage

// File: rtl/sig_sync_chan.sv
// ----------------------------------------------------------------------------
// sig_sync_chan
//   One channel of the synchronizer bank: STAGES-deep synchronizer chain,
//   optional stability filter, registered rise/fall pulses and a sticky
//   event-pending flag with synchronous clear.
//   Build option: define SIG_SYNC_BANK_FILTER_EN to require FILTER_CYCLES
//   consecutive cycles of a new level at the chain output before out_sync
//   follows; otherwise out_sync follows the chain output every cycle.
//   Ports:
//     clock     in   sole clock
//     reset_n   in   asynchronous active-low reset
//     in_async  in   asynchronous level input
//     evt_clr   in   synchronous clear of the pending flag
//     chan_out  out  {sync level, rise pulse, fall pulse, pending flag}
// ----------------------------------------------------------------------------
module sig_sync_chan
    import sig_sync_pkg::*;
#(
    parameter int   STAGES        = 2,
    parameter logic RESET_VAL     = 1'b0,
    parameter int   FILTER_CYCLES = 4
) (
    input  logic      clock,
    input  logic      reset_n,
    input  logic      in_async,
    input  logic      evt_clr,
    output chan_out_t chan_out
);

    generate
        if (!params_legal(1, STAGES, FILTER_CYCLES)) begin : g_param_check
            $error("sig_sync_chan: STAGES must be >= 2 and FILTER_CYCLES >= 1");
        end
    endgenerate

    (* async_reg = "true" *) logic [STAGES-1:0] sync_chain;

    logic s_last;
    logic sync_q;
    logic sync_next;
    logic rise_q;
    logic fall_q;
    logic pend_q;

    // Plain shift chain: no logic between the flops so the metastability
    // resolution time of each stage is a full clock period.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sync_chain <= {STAGES{RESET_VAL}};
        end else begin
            sync_chain <= {sync_chain[STAGES-2:0], in_async};
        end
    end

    assign s_last = sync_chain[STAGES-1];

`ifdef SIG_SYNC_BANK_FILTER_EN
    localparam int              CNT_W    = cnt_width(FILTER_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILTER_CYCLES - 1);

    logic [CNT_W-1:0] stable_cnt;
    logic [CNT_W-1:0] stable_cnt_next;

    // Count cycles in which the chain output disagrees with the published
    // level. Any agreement restarts the count, so short pulses never make
    // it out; the level is accepted on the FILTER_CYCLES-th disagreement.
    always_comb begin
        stable_cnt_next = '0;
        sync_next       = sync_q;
        if (s_last != sync_q) begin
            if (stable_cnt == CNT_LAST) begin
                sync_next = s_last;
            end else begin
                stable_cnt_next = stable_cnt + CNT_W'(1);
            end
        end
    end

    // Counter register; reset clears it even in the middle of a filter window.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            stable_cnt <= '0;
        end else begin
            stable_cnt <= stable_cnt_next;
        end
    end
`else
    // Without the filter the published level simply trails the chain.
    always_comb begin
        sync_next = s_last;
    end
`endif

    // Edge pulses compare the level about to be published with the current
    // one, so each pulse is high in exactly the cycle out_sync shows the new
    // value. The pending flag is fed by the registered pulses, and a set
    // overrides a simultaneous clear so no event is ever lost.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= RESET_VAL;
            rise_q <= 1'b0;
            fall_q <= 1'b0;
            pend_q <= 1'b0;
        end else begin
            sync_q <= sync_next;
            rise_q <= sync_next & ~sync_q;
            fall_q <= ~sync_next & sync_q;
            pend_q <= (pend_q & ~evt_clr) | rise_q | fall_q;
        end
    end

    assign chan_out.sync = sync_q;
    assign chan_out.rise = rise_q;
    assign chan_out.fall = fall_q;
    assign chan_out.pend = pend_q;

endmodule

// File: rtl/sig_sync_bank.sv
// ----------------------------------------------------------------------------
// sig_sync_bank
//   WIDTH independent asynchronous level inputs brought into the clock
//   domain, each with edge pulses and a sticky event flag. Sits between pad
//   or async sources (GPIO, external interrupts, straps) and core logic.
//   Build option: SIG_SYNC_BANK_FILTER_EN enables the per-channel stability
//   filter of FILTER_CYCLES cycles (FILTER_CYCLES ignored otherwise).
//   Ports:
//     clock     in   1      sole clock
//     reset_n   in   1      asynchronous active-low reset
//     in_async  in   WIDTH  asynchronous level inputs
//     out_sync  out  WIDTH  synchronized (filtered) levels, reset RESET_VAL
//     out_rise  out  WIDTH  one-cycle pulse when out_sync goes 0->1
//     out_fall  out  WIDTH  one-cycle pulse when out_sync goes 1->0
//     evt_pend  out  WIDTH  sticky flag set by any rise/fall pulse
//     evt_clr   in   WIDTH  synchronous per-bit clear of evt_pend
// ----------------------------------------------------------------------------
module sig_sync_bank
    import sig_sync_pkg::*;
#(
    parameter int               WIDTH         = 4,
    parameter int               STAGES        = 2,
    parameter logic [WIDTH-1:0] RESET_VAL     = '0,
    parameter int               FILTER_CYCLES = 4
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] in_async,
    output logic [WIDTH-1:0] out_sync,
    output logic [WIDTH-1:0] out_rise,
    output logic [WIDTH-1:0] out_fall,
    output logic [WIDTH-1:0] evt_pend,
    input  logic [WIDTH-1:0] evt_clr
);

    generate
        if (!params_legal(WIDTH, STAGES, FILTER_CYCLES)) begin : g_param_check
            $error("sig_sync_bank: WIDTH >= 1, STAGES >= 2, FILTER_CYCLES >= 1 required");
        end
    endgenerate

    chan_out_t chan_out [WIDTH];

    // Channels share nothing but clock and reset; each gets its own bit of
    // the reset value.
    for (genvar i = 0; i < WIDTH; i++) begin : g_chan
        sig_sync_chan #(
            .STAGES        (STAGES),
            .RESET_VAL     (RESET_VAL[i]),
            .FILTER_CYCLES (FILTER_CYCLES)
        ) u_chan (
            .clock    (clock),
            .reset_n  (reset_n),
            .in_async (in_async[i]),
            .evt_clr  (evt_clr[i]),
            .chan_out (chan_out[i])
        );

        assign out_sync[i] = chan_out[i].sync;
        assign out_rise[i] = chan_out[i].rise;
        assign out_fall[i] = chan_out[i].fall;
        assign evt_pend[i] = chan_out[i].pend;
    end

endmodule

// File: tb/tb_sig_sync_bank.sv
// ----------------------------------------------------------------------------
// tb_sig_sync_bank
//   Self-checking bench for sig_sync_bank (WIDTH=4, STAGES=3, RESET_VAL=0,
//   FILTER_CYCLES=4). Honors SIG_SYNC_BANK_FILTER_EN to pick the expected
//   filter behaviour. The reference model keeps a history of sampled inputs:
//   out_sync switches once the chain-delayed input has shown the opposite
//   level for the whole filter window.
// ----------------------------------------------------------------------------
module tb_sig_sync_bank;

    localparam int               WIDTH         = 4;
    localparam int               STAGES        = 3;
    localparam int               FILTER_CYCLES = 4;
    localparam logic [WIDTH-1:0] RESET_VAL     = '0;
`ifdef SIG_SYNC_BANK_FILTER_EN
    localparam int EFF_FILTER = FILTER_CYCLES;
`else
    localparam int EFF_FILTER = 1;
`endif
    localparam int LAT        = STAGES + EFF_FILTER;
    localparam int HIST_LEN   = STAGES + EFF_FILTER;
    localparam int WAIT_LIMIT = 4 * LAT + 20;

    logic             clock    = 1'b0;
    logic             reset_n  = 1'b0;
    logic [WIDTH-1:0] in_async = '0;
    logic [WIDTH-1:0] evt_clr  = '0;
    logic [WIDTH-1:0] out_sync;
    logic [WIDTH-1:0] out_rise;
    logic [WIDTH-1:0] out_fall;
    logic [WIDTH-1:0] evt_pend;

    int tests_run    = 0;
    int tests_failed = 0;

    logic [WIDTH-1:0] hist [$];
    logic [WIDTH-1:0] m_sync;
    logic [WIDTH-1:0] m_rise;
    logic [WIDTH-1:0] m_fall;
    logic [WIDTH-1:0] m_evt;

    sig_sync_bank #(
        .WIDTH         (WIDTH),
        .STAGES        (STAGES),
        .RESET_VAL     (RESET_VAL),
        .FILTER_CYCLES (FILTER_CYCLES)
    ) dut (
        .clock    (clock),
        .reset_n  (reset_n),
        .in_async (in_async),
        .out_sync (out_sync),
        .out_rise (out_rise),
        .out_fall (out_fall),
        .evt_pend (evt_pend),
        .evt_clr  (evt_clr)
    );

    always #5 clock = ~clock;

    task automatic model_reset();
        hist.delete();
        for (int i = 0; i < HIST_LEN; i++) begin
            hist.push_back(RESET_VAL);
        end
        m_sync = RESET_VAL;
        m_rise = '0;
        m_fall = '0;
        m_evt  = '0;
    endtask

    // hist[0] is the input sampled at this edge; hist[STAGES+j] is what the
    // last chain flop showed j edges ago.
    task automatic model_step();
        logic [WIDTH-1:0] ns;
        logic [WIDTH-1:0] h;
        logic [WIDTH-1:0] dropped;
        bit               flip;
        if (!reset_n) begin
            model_reset();
            return;
        end
        hist.push_front(in_async);
        dropped = hist.pop_back();
        ns = m_sync;
        for (int b = 0; b < WIDTH; b++) begin
            flip = 1'b1;
            for (int j = 0; j < EFF_FILTER; j++) begin
                h = hist[STAGES + j];
                if (h[b] == m_sync[b]) flip = 1'b0;
            end
            if (flip) ns[b] = ~m_sync[b];
        end
        m_evt  = (m_evt & ~evt_clr) | m_rise | m_fall;
        m_rise = ns & ~m_sync;
        m_fall = ~ns & m_sync;
        m_sync = ns;
    endtask

    task automatic step();
        @(posedge clock);
        model_step();
        #1;
    endtask

    task automatic settle(input logic [WIDTH-1:0] level);
        in_async = level;
        evt_clr  = '0;
        repeat (LAT + 3) step();
        evt_clr = '1;
        step();
        evt_clr = '0;
        step();
    endtask

    task automatic test_reset();
        model_reset();
        reset_n = 1'b0;
        repeat (2) step();
        reset_n  = 1'b1;
        in_async = 4'hF;
        repeat (LAT + 3) step();
        #2;
        reset_n = 1'b0;
        model_reset();
        #1;
        tests_run++;
        if (out_sync !== 4'h0) begin tests_failed++; $display("[TB] FAIL reset_sync: got %h expected 0", out_sync); end
        tests_run++;
        if (out_rise !== 4'h0) begin tests_failed++; $display("[TB] FAIL reset_rise: got %h expected 0", out_rise); end
        tests_run++;
        if (out_fall !== 4'h0) begin tests_failed++; $display("[TB] FAIL reset_fall: got %h expected 0", out_fall); end
        tests_run++;
        if (evt_pend !== 4'h0) begin tests_failed++; $display("[TB] FAIL reset_evt: got %h expected 0", evt_pend); end
        repeat (2) step();
        reset_n = 1'b1;
        for (int e = 1; e <= LAT + 1; e++) begin
            step();
            tests_run++;
            if (out_sync !== ((e >= LAT) ? 4'hF : 4'h0)) begin
                tests_failed++;
                $display("[TB] FAIL release_sync edge %0d: got %h expected %h", e, out_sync, (e >= LAT) ? 4'hF : 4'h0);
            end
            tests_run++;
            if (out_rise !== ((e == LAT) ? 4'hF : 4'h0) || out_fall !== 4'h0) begin
                tests_failed++;
                $display("[TB] FAIL release_pulse edge %0d: got rise %h fall %h expected rise %h fall 0", e, out_rise, out_fall, (e == LAT) ? 4'hF : 4'h0);
            end
            tests_run++;
            if (evt_pend !== ((e == LAT + 1) ? 4'hF : 4'h0)) begin
                tests_failed++;
                $display("[TB] FAIL release_evt edge %0d: got %h expected %h", e, evt_pend, (e == LAT + 1) ? 4'hF : 4'h0);
            end
        end
    endtask

    task automatic test_latency();
        settle(4'h0);
        in_async[0] = 1'b1;
        for (int e = 1; e <= LAT + 1; e++) begin
            step();
            tests_run++;
            if (out_sync[0] !== (e >= LAT) || out_rise !== ((e == LAT) ? 4'h1 : 4'h0)) begin
                tests_failed++;
                $display("[TB] FAIL latency edge %0d: got sync0 %b rise %h expected sync0 %b rise %h", e, out_sync[0], out_rise, (e >= LAT), (e == LAT) ? 4'h1 : 4'h0);
            end
        end
    endtask

`ifdef SIG_SYNC_BANK_FILTER_EN
    task automatic test_filter();
        settle(4'h0);
        in_async[0] = 1'b1;
        repeat (3) step();
        in_async[0] = 1'b0;
        for (int e = 4; e <= LAT + 8; e++) begin
            step();
            tests_run++;
            if (out_sync !== 4'h0 || out_rise !== 4'h0 || evt_pend !== 4'h0) begin
                tests_failed++;
                $display("[TB] FAIL glitch edge %0d: got sync %h rise %h evt %h expected 0 0 0", e, out_sync, out_rise, evt_pend);
            end
        end
        settle(4'h0);
        in_async[0] = 1'b1;
        for (int e = 1; e <= LAT + 8; e++) begin
            step();
            if (e == 5) in_async[0] = 1'b0;
            tests_run++;
            if (out_sync[0] !== (e >= LAT && e < LAT + 5) ||
                out_rise[0] !== (e == LAT) || out_fall[0] !== (e == LAT + 5)) begin
                tests_failed++;
                $display("[TB] FAIL long_pulse edge %0d: got sync %b rise %b fall %b expected %b %b %b", e, out_sync[0], out_rise[0], out_fall[0], (e >= LAT && e < LAT + 5), (e == LAT), (e == LAT + 5));
            end
        end
    endtask
`endif

    task automatic test_sticky();
        bit found;
        settle(4'h0);
        in_async = 4'h4;
        found = 1'b0;
        for (int i = 0; i < WAIT_LIMIT && !found; i++) begin
            step();
            if (out_rise[2]) found = 1'b1;
        end
        tests_run++;
        if (!found) begin tests_failed++; $display("[TB] FAIL sticky_rise_wait: got no rise expected rise on ch2"); end
        step();
        tests_run++;
        if (evt_pend !== 4'h4) begin tests_failed++; $display("[TB] FAIL sticky_set: got %h expected 4", evt_pend); end
        in_async = 4'h0;
        found = 1'b0;
        for (int i = 0; i < WAIT_LIMIT && !found; i++) begin
            step();
            if (out_fall[2]) found = 1'b1;
        end
        tests_run++;
        if (!found) begin tests_failed++; $display("[TB] FAIL sticky_fall_wait: got no fall expected fall on ch2"); end
        evt_clr = 4'h4;
        step();
        tests_run++;
        if (evt_pend[2] !== 1'b1) begin tests_failed++; $display("[TB] FAIL sticky_set_wins: got %b expected 1", evt_pend[2]); end
        step();
        tests_run++;
        if (evt_pend !== 4'h0) begin tests_failed++; $display("[TB] FAIL sticky_clear: got %h expected 0", evt_pend); end
        evt_clr = 4'h0;
    endtask

    task automatic test_parallel();
        bit found;
        settle(4'h0);
        in_async = 4'hA;
        found = 1'b0;
        for (int i = 0; i < WAIT_LIMIT && !found; i++) begin
            step();
            if ((out_rise | out_fall) != 4'h0) found = 1'b1;
        end
        tests_run++;
        if (!found || out_rise !== 4'hA || out_fall !== 4'h0) begin
            tests_failed++;
            $display("[TB] FAIL parallel_rise: got rise %h fall %h expected rise a fall 0", out_rise, out_fall);
        end
        in_async = 4'h5;
        found = 1'b0;
        for (int i = 0; i < WAIT_LIMIT && !found; i++) begin
            step();
            if ((out_rise | out_fall) != 4'h0) found = 1'b1;
        end
        tests_run++;
        if (!found || out_rise !== 4'h5 || out_fall !== 4'hA) begin
            tests_failed++;
            $display("[TB] FAIL parallel_swap: got rise %h fall %h expected rise 5 fall a", out_rise, out_fall);
        end
    endtask

    task automatic test_random();
        for (int cyc = 0; cyc < 10000; cyc++) begin
            for (int b = 0; b < WIDTH; b++) begin
                if ($urandom_range(0, 7) == 0) in_async[b] = ~in_async[b];
                evt_clr[b] = ($urandom_range(0, 15) == 0);
            end
            if (cyc == 3000 || cyc == 7000) begin
                #2;
                reset_n = 1'b0;
                model_reset();
                #1;
                tests_run++;
                if ({out_sync, out_rise, out_fall, evt_pend} !== {RESET_VAL, 12'h000}) begin
                    tests_failed++;
                    $display("[TB] FAIL rand_reset cyc %0d: got %h expected %h", cyc, {out_sync, out_rise, out_fall, evt_pend}, {RESET_VAL, 12'h000});
                end
                repeat (2) step();
                reset_n = 1'b1;
            end
            step();
            tests_run++;
            if (out_sync !== m_sync) begin tests_failed++; $display("[TB] FAIL rand_sync cyc %0d: got %h expected %h", cyc, out_sync, m_sync); end
            tests_run++;
            if (out_rise !== m_rise) begin tests_failed++; $display("[TB] FAIL rand_rise cyc %0d: got %h expected %h", cyc, out_rise, m_rise); end
            tests_run++;
            if (out_fall !== m_fall) begin tests_failed++; $display("[TB] FAIL rand_fall cyc %0d: got %h expected %h", cyc, out_fall, m_fall); end
            tests_run++;
            if (evt_pend !== m_evt) begin tests_failed++; $display("[TB] FAIL rand_evt cyc %0d: got %h expected %h", cyc, evt_pend, m_evt); end
            tests_run++;
            if ((out_rise & out_fall) !== 4'h0) begin tests_failed++; $display("[TB] FAIL rand_overlap cyc %0d: got %h expected 0", cyc, out_rise & out_fall); end
        end
        evt_clr = '0;
    endtask

    initial begin
        test_reset();
        test_latency();
`ifdef SIG_SYNC_BANK_FILTER_EN
        test_filter();
`endif
        test_sticky();
        test_parallel();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
